// File: rtl/ifft8_seq.sv
// Sequential 8-point inverse FFT (radix-2 DIT, one shared butterfly), Q16.16 complex samples.
// Optional build macro IFFT_SCALE_EN: halve every butterfly output for a true 1/N inverse.
module ifft8_seq #(
    parameter int W    = 32,
    parameter int FRAC = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_re,
    input  logic [W-1:0] in_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    output logic         out_last,
    output logic         busy
);

    // state     | meaning
    // S_LOAD    | accept X[k], written at bitrev3(k)
    // S_COMPUTE | 12 cycles: 3 stages x 4 butterflies
    // S_UNLOAD  | stream x[0..7] under out_ready backpressure
    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

    state_t state, state_nxt;

    logic [2:0] load_cnt;
    logic [2:0] out_cnt;
    logic [3:0] bf_cnt;

    logic signed [W-1:0] buf_re [8];
    logic signed [W-1:0] buf_im [8];

    logic [1:0] stage;
    logic [1:0] bidx;
    logic [2:0] idx_a;
    logic [2:0] idx_b;
    logic [1:0] tw;
    logic signed [W-1:0] tw_c, tw_s;
    logic signed [W-1:0] a_re, a_im, b_re, b_im;
    logic signed [W-1:0] bw_re, bw_im;
    logic signed [W-1:0] sum_re, sum_im, dif_re, dif_im;
    logic signed [W-1:0] new_a_re, new_a_im, new_b_re, new_b_im;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        out_re    = '0;
        out_im    = '0;
        case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && load_cnt == 3'd7) state_nxt = S_COMPUTE;
            end
            S_COMPUTE: begin
                busy = 1'b1;
                if (bf_cnt == 4'd11) state_nxt = S_UNLOAD;
            end
            S_UNLOAD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_re    = buf_re[out_cnt];
                out_im    = buf_im[out_cnt];
                out_last  = (out_cnt == 3'd7);
                if (out_ready && out_cnt == 3'd7) state_nxt = S_LOAD;
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    // Butterfly schedule: bf_cnt[3:2] is the stage, bf_cnt[1:0] the butterfly within it.
    always_comb begin
        stage = bf_cnt[3:2];
        bidx  = bf_cnt[1:0];
        idx_a = '0;
        tw    = '0;
        case (stage)
            2'd0: begin idx_a = {bidx, 1'b0};              tw = 2'd0;            end
            2'd1: begin idx_a = {bidx[1], 1'b0, bidx[0]};  tw = {bidx[0], 1'b0}; end
            2'd2: begin idx_a = {1'b0, bidx};              tw = bidx;            end
            default: begin idx_a = '0;                     tw = 2'd0;            end
        endcase
        idx_b = idx_a | (3'b001 << stage);
    end

    always_comb begin
        tw_c = 32'sh0001_0000;
        tw_s = 32'sh0000_0000;
        case (tw)
            2'd0: begin tw_c = 32'sh0001_0000; tw_s = 32'sh0000_0000; end
            2'd1: begin tw_c = 32'sh0000_B505; tw_s = 32'sh0000_B505; end
            2'd2: begin tw_c = 32'sh0000_0000; tw_s = 32'sh0001_0000; end
            default: begin tw_c = 32'shFFFF_4AFB; tw_s = 32'sh0000_B505; end
        endcase
    end

    always_comb begin
        a_re = buf_re[idx_a];
        a_im = buf_im[idx_a];
        b_re = buf_re[idx_b];
        b_im = buf_im[idx_b];
        if (tw == 2'd0) begin
            bw_re = b_re;
            bw_im = b_im;
        end else begin
            // Full 64-bit products, sum, then keep bits [47:16] (truncating).
            bw_re = W'((64'(b_re) * 64'(tw_c) - 64'(b_im) * 64'(tw_s)) >>> FRAC);
            bw_im = W'((64'(b_re) * 64'(tw_s) + 64'(b_im) * 64'(tw_c)) >>> FRAC);
        end
        sum_re = a_re + bw_re;
        sum_im = a_im + bw_im;
        dif_re = a_re - bw_re;
        dif_im = a_im - bw_im;
`ifdef IFFT_SCALE_EN
        new_a_re = sum_re >>> 1;
        new_a_im = sum_im >>> 1;
        new_b_re = dif_re >>> 1;
        new_b_im = dif_im >>> 1;
`else
        new_a_re = sum_re;
        new_a_im = sum_im;
        new_b_re = dif_re;
        new_b_im = dif_im;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt <= '0;
            out_cnt  <= '0;
            bf_cnt   <= '0;
            for (int i = 0; i < 8; i++) begin
                buf_re[i] <= '0;
                buf_im[i] <= '0;
            end
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        buf_re[{load_cnt[0], load_cnt[1], load_cnt[2]}] <= in_re;
                        buf_im[{load_cnt[0], load_cnt[1], load_cnt[2]}] <= in_im;
                        load_cnt <= load_cnt + 3'd1;
                    end
                end
                S_COMPUTE: begin
                    buf_re[idx_a] <= new_a_re;
                    buf_im[idx_a] <= new_a_im;
                    buf_re[idx_b] <= new_b_re;
                    buf_im[idx_b] <= new_b_im;
                    bf_cnt <= (bf_cnt == 4'd11) ? 4'd0 : bf_cnt + 4'd1;
                end
                S_UNLOAD: begin
                    if (out_ready) out_cnt <= out_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifft8_seq.sv
// Scoreboard bench for ifft8_seq: expected x[n] queued at drive time, popped on each output beat.
// Expected values come from constants and a loop-based fixed-point inverse FFT model.
module tb_ifft8_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_re = '0;
    logic [31:0] in_im = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_re;
    logic [31:0] out_im;
    logic        out_last;
    logic        busy;

    ifft8_seq #(.W(32), .FRAC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int out_beats = 0;
    logic [64:0] exp_q[$];
    logic [64:0] exp_e;

    logic signed [31:0] f_re [8];
    logic signed [31:0] f_im [8];

`ifdef IFFT_SCALE_EN
    localparam logic [31:0] IMP_VAL  = 32'h0000_2000;
    localparam logic [31:0] ONES_DC  = 32'h0001_0000;
`else
    localparam logic [31:0] IMP_VAL  = 32'h0001_0000;
    localparam logic [31:0] ONES_DC  = 32'h0008_0000;
`endif

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mul_q16(input logic signed [31:0] x, input logic signed [31:0] y,
                                            input logic signed [31:0] u, input logic signed [31:0] v,
                                            input bit plus);
        logic signed [63:0] p;
        p = plus ? (64'(x) * 64'(y) + 64'(u) * 64'(v)) : (64'(x) * 64'(y) - 64'(u) * 64'(v));
        return p[47:16];
    endfunction

    // Stage/group/member loop model of the DIT with the same fixed-point rules.
    function automatic void push_model();
        logic signed [31:0] ar [8];
        logic signed [31:0] ai [8];
        logic signed [31:0] tc [4];
        logic signed [31:0] ts [4];
        logic signed [31:0] wr, wi, sr, si, dr, di;
        int h, i, j, t;
        tc[0] = 32'sh0001_0000; tc[1] = 32'sh0000_B505; tc[2] = 32'sh0; tc[3] = 32'shFFFF_4AFB;
        ts[0] = 32'sh0;         ts[1] = 32'sh0000_B505; ts[2] = 32'sh0001_0000; ts[3] = 32'sh0000_B505;
        for (int k = 0; k < 8; k++) begin
            ar[((k & 1) << 2) | (k & 2) | ((k >> 2) & 1)] = f_re[k];
            ai[((k & 1) << 2) | (k & 2) | ((k >> 2) & 1)] = f_im[k];
        end
        for (int s = 0; s < 3; s++) begin
            h = 1 << s;
            for (int g = 0; g < 8; g += 2 * h) begin
                for (int m = 0; m < h; m++) begin
                    i = g + m;
                    j = i + h;
                    t = m * (4 / h);
                    if (t == 0) begin
                        wr = ar[j];
                        wi = ai[j];
                    end else begin
                        wr = mul_q16(ar[j], tc[t], ai[j], ts[t], 1'b0);
                        wi = mul_q16(ar[j], ts[t], ai[j], tc[t], 1'b1);
                    end
                    sr = ar[i] + wr; si = ai[i] + wi;
                    dr = ar[i] - wr; di = ai[i] - wi;
`ifdef IFFT_SCALE_EN
                    sr = sr >>> 1; si = si >>> 1; dr = dr >>> 1; di = di >>> 1;
`endif
                    ar[i] = sr; ai[i] = si; ar[j] = dr; ai[j] = di;
                end
            end
        end
        for (int n = 0; n < 8; n++) exp_q.push_back({(n == 7), ar[n], ai[n]});
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            check_val("in_ready_during_unload", in_ready, 1'b0);
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check_val("out_re", out_re, exp_e[63:32]);
                    check_val("out_im", out_im, exp_e[31:0]);
                    check_val("out_last", out_last, exp_e[64]);
                end
                out_beats++;
            end
        end
    end

    task automatic drive_frame(input bit gapped, input bit hold_valid, input bit bp, input bit abort);
        int cyc;
        int base;
        logic [31:0] hr, hi;
        base = out_beats;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_re = f_re[k];
            in_im = f_im[k];
            @(posedge clk); #1;
            if (gapped && k < 7) begin
                in_valid = 1'b0;
                in_re = $urandom;
                in_im = $urandom;
                @(posedge clk); #1;
            end
        end
        if (hold_valid) begin
            in_re = $urandom;
            in_im = $urandom;
        end else begin
            in_valid = 1'b0;
        end
        check_val("in_ready_after_8th", in_ready, 1'b0);
        check_val("busy_after_8th", busy, 1'b1);
        if (abort) begin
            repeat (5) @(posedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            check_val("abort_in_ready", in_ready, 1'b1);
            check_val("abort_busy", busy, 1'b0);
            check_val("abort_out_valid", out_valid, 1'b0);
            check_val("abort_out_data", {out_re, out_im}, 64'h0);
            check_val("abort_out_last", out_last, 1'b0);
            #20;
            rst_n = 1'b1;
            @(posedge clk); #1;
            check_val("in_ready_after_release", in_ready, 1'b1);
            return;
        end
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check_val("latency", cyc, 12);
        if (bp) begin
            cyc = 0;
            while (out_beats - base < 3 && cyc < 40) begin
                @(posedge clk); #1;
                cyc++;
            end
            out_ready = 1'b0;
            hr = out_re;
            hi = out_im;
            repeat (5) begin
                @(posedge clk); #1;
                check_val("bp_hold_re", out_re, hr);
                check_val("bp_hold_im", out_im, hi);
                check_val("bp_hold_valid", out_valid, 1'b1);
            end
            out_ready = 1'b1;
        end
        cyc = 0;
        while (out_valid && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val("unload_done", out_valid, 1'b0);
        check_val("beats_per_frame", out_beats - base, 8);
        check_val("queue_drained", exp_q.size(), 0);
        check_val("in_ready_after_frame", in_ready, 1'b1);
    endtask

    initial begin
        #12;
        check_val("rst_in_ready", in_ready, 1'b1);
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_out_data", {out_re, out_im}, 64'h0);
        check_val("rst_out_last", out_last, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 8; k++) begin f_re[k] = 0; f_im[k] = 0; end
        f_re[0] = 32'sh0001_0000;
        for (int n = 0; n < 8; n++) exp_q.push_back({(n == 7), IMP_VAL, 32'h0});
        drive_frame(1'b0, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 8; k++) begin f_re[k] = 32'sh0001_0000; f_im[k] = 0; end
        exp_q.push_back({1'b0, ONES_DC, 32'h0});
        for (int n = 1; n < 8; n++) exp_q.push_back({(n == 7), 32'h0, 32'h0});
        drive_frame(1'b0, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 8; k++) begin f_re[k] = 0; f_im[k] = 0; end
        f_re[1] = 32'sh0001_0000;
        push_model();
        drive_frame(1'b1, 1'b1, 1'b0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            f_re[k] = $signed(32'($urandom_range(0, 32'h0004_0000))) - 32'sh0002_0000;
            f_im[k] = $signed(32'($urandom_range(0, 32'h0004_0000))) - 32'sh0002_0000;
        end
        push_model();
        drive_frame(1'b0, 1'b0, 1'b1, 1'b0);

        for (int k = 0; k < 8; k++) begin f_re[k] = 32'sh7000_0000; f_im[k] = 32'sh1234_5678; end
        drive_frame(1'b0, 1'b0, 1'b0, 1'b1);

        for (int k = 0; k < 8; k++) begin
            f_re[k] = $signed(32'($urandom_range(0, 32'h0010_0000))) - 32'sh0008_0000;
            f_im[k] = $signed(32'($urandom_range(0, 32'h0010_0000))) - 32'sh0008_0000;
        end
        push_model();
        drive_frame(1'b1, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
